// File: rtl/data_sram_arb.sv
// data_sram_arb: two-port arbiter/sequencer sharing the single-ported data SRAM.
// Latency: grant is combinational; read data returned on mN_rvalid two cycles after grant.
// Backpressure: a port holding an unconsumed response (RESP) is not granted until mN_rready.
//
// Ports (N = 0 load/store unit, N = 1 debug/DMA):
//   clk, resetn          - rising-edge clock, synchronous active-low reset
//   mN_req/wen/addr/wdata - access request from port N (write when wen = 1)
//   mN_gnt               - combinational accept for the current cycle
//   mN_rvalid/rdata/rready - per-port read response register with valid/ready handshake
//   data_sram_*          - SRAM enable, write enable, address, write data and read data
//
// Build option: define DATA_SRAM_ARB_RR_EN for round-robin arbitration between
// simultaneously eligible ports; otherwise port 0 has fixed priority.
module data_sram_arb #(
    parameter int AW = 64,
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          resetn,

    input  logic          m0_req,
    input  logic          m0_wen,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m0_rready,

    input  logic          m1_req,
    input  logic          m1_wen,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    input  logic          m1_rready,

    output logic          data_sram_en,
    output logic          data_sram_wen,
    output logic [AW-1:0] data_sram_addr,
    output logic [DW-1:0] data_sram_wdata,
    input  logic [DW-1:0] data_sram_rdata
);

    typedef enum logic [1:0] {
        FREE     = 2'd0,
        INFLIGHT = 2'd1,
        RESP     = 2'd2
    } state_t;

    state_t          st0_q, st0_d;
    state_t          st1_q, st1_d;
    logic            last_q, last_d;
    logic [DW-1:0]   rdata0_q, rdata0_d;
    logic [DW-1:0]   rdata1_q, rdata1_d;

    logic            elig0, elig1;
    logic            gnt0, gnt1;

    // Per-port sequencing: only a granted read leaves FREE; writes are fire-and-forget.
    function automatic state_t next_state(input state_t st, input logic gnt,
                                          input logic wen, input logic rready);
        state_t nxt;
        nxt = st;
        case (st)
            FREE:     if (gnt && !wen) nxt = INFLIGHT;
            INFLIGHT: nxt = RESP;
            RESP:     if (rready) nxt = FREE;
            default:  nxt = FREE;
        endcase
        return nxt;
    endfunction

    // Arbitration. A port in RESP stays ineligible for the cycle its response is
    // consumed, so it can never be granted while its response register is occupied.
    always_comb begin
        elig0 = m0_req && (st0_q == FREE);
        elig1 = m1_req && (st1_q == FREE);
`ifdef DATA_SRAM_ARB_RR_EN
        // Contention goes to the port that was not granted most recently.
        gnt0  = elig0 && (!elig1 || last_q);
        gnt1  = elig1 && (!elig0 || !last_q);
`else
        gnt0  = elig0;
        gnt1  = elig1 && !elig0;
`endif
        // Every combinational output is forced low while reset is held.
        gnt0  = gnt0 && resetn;
        gnt1  = gnt1 && resetn;
    end

    assign m0_gnt = gnt0;
    assign m1_gnt = gnt1;

    // SRAM drive: idle cycles present a clean all-zero command.
    always_comb begin
        data_sram_en    = 1'b0;
        data_sram_wen   = 1'b0;
        data_sram_addr  = '0;
        data_sram_wdata = '0;
        if (gnt0) begin
            data_sram_en    = 1'b1;
            data_sram_wen   = m0_wen;
            data_sram_addr  = m0_addr;
            data_sram_wdata = m0_wdata;
        end else if (gnt1) begin
            data_sram_en    = 1'b1;
            data_sram_wen   = m1_wen;
            data_sram_addr  = m1_addr;
            data_sram_wdata = m1_wdata;
        end
    end

    // Next state. The capture in INFLIGHT uses the read issued in the previous
    // cycle, so a concurrent access by the other port does not disturb it.
    always_comb begin
        st0_d    = next_state(st0_q, gnt0, m0_wen, m0_rready);
        st1_d    = next_state(st1_q, gnt1, m1_wen, m1_rready);
        rdata0_d = (st0_q == INFLIGHT) ? data_sram_rdata : rdata0_q;
        rdata1_d = (st1_q == INFLIGHT) ? data_sram_rdata : rdata1_q;
        last_d   = last_q;
        if (gnt1) begin
            last_d = 1'b1;
        end else if (gnt0) begin
            last_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            st0_q    <= FREE;
            st1_q    <= FREE;
            last_q   <= 1'b1;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            st0_q    <= st0_d;
            st1_q    <= st1_d;
            last_q   <= last_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign m0_rvalid = resetn && (st0_q == RESP);
    assign m1_rvalid = resetn && (st1_q == RESP);
    assign m0_rdata  = rdata0_q;
    assign m1_rdata  = rdata1_q;

endmodule
